// File: rtl/axis_budget_arbiter.sv
// Two-source AXI-Stream arbiter with packet-granular round-robin and a
// per-source beat budget that refills every CLOCKS_PER_USEC cycles.
module axis_budget_arbiter #(
    parameter int DW              = 512,
    parameter int CLOCKS_PER_USEC = 250
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DW-1:0]     S0_AXIS_TDATA,
    input  logic [DW/8-1:0]   S0_AXIS_TKEEP,
    input  logic              S0_AXIS_TLAST,
    input  logic              S0_AXIS_TVALID,
    output logic              S0_AXIS_TREADY,
    input  logic [DW-1:0]     S1_AXIS_TDATA,
    input  logic [DW/8-1:0]   S1_AXIS_TKEEP,
    input  logic              S1_AXIS_TLAST,
    input  logic              S1_AXIS_TVALID,
    output logic              S1_AXIS_TREADY,
    output logic [DW-1:0]     M_AXIS_TDATA,
    output logic [DW/8-1:0]   M_AXIS_TKEEP,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TUSER,
    input  logic [15:0]       BUDGET0,
    input  logic [15:0]       BUDGET1,
    output logic [1:0]        GRANT
);

    localparam int            CW       = $clog2(CLOCKS_PER_USEC + 1);
    localparam logic [CW-1:0] WRAP_VAL = CW'(CLOCKS_PER_USEC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cycle_count_q, cycle_count_d;
    logic [15:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [15:0]   r_budget0_q, r_budget1_q;

    logic ok0_s, ok1_s, elig0_s, elig1_s, wrap_s, hs0_s, hs1_s;

    assign ok0_s   = (cnt0_q < r_budget0_q);
    assign ok1_s   = (cnt1_q < r_budget1_q);
    assign elig0_s = S0_AXIS_TVALID & ok0_s;
    assign elig1_s = S1_AXIS_TVALID & ok1_s;
    assign wrap_s  = (cycle_count_q == WRAP_VAL);
    assign hs0_s   = (state_q == ST_BUSY0) & elig0_s & M_AXIS_TREADY;
    assign hs1_s   = (state_q == ST_BUSY1) & elig1_s & M_AXIS_TREADY;

    // Window counter and beat counters; a wrap clear beats a same-cycle increment.
    always_comb begin
        cycle_count_d = cycle_count_q + CW'(1);
        cnt0_d        = cnt0_q;
        cnt1_d        = cnt1_q;
        if (wrap_s) begin
            cycle_count_d = CW'(1);
            cnt0_d        = 16'h0000;
            cnt1_d        = 16'h0000;
        end else begin
            if (hs0_s && (cnt0_q != 16'hFFFF)) begin
                cnt0_d = cnt0_q + 16'h0001;
            end else begin
                cnt0_d = cnt0_q;
            end
            if (hs1_s && (cnt1_q != 16'hFFFF)) begin
                cnt1_d = cnt1_q + 16'h0001;
            end else begin
                cnt1_d = cnt1_q;
            end
        end
    end

    // Arbitration FSM next state and the granted-port datapath mux.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        M_AXIS_TDATA   = S0_AXIS_TDATA;
        M_AXIS_TKEEP   = S0_AXIS_TKEEP;
        M_AXIS_TLAST   = S0_AXIS_TLAST;
        M_AXIS_TVALID  = 1'b0;
        M_AXIS_TUSER   = 1'b0;
        S0_AXIS_TREADY = 1'b0;
        S1_AXIS_TREADY = 1'b0;
        GRANT          = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (elig0_s && elig1_s) begin
                    state_d = last_grant_q ? ST_BUSY0 : ST_BUSY1;
                end else if (elig0_s) begin
                    state_d = ST_BUSY0;
                end else if (elig1_s) begin
                    state_d = ST_BUSY1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY0: begin
                M_AXIS_TVALID  = elig0_s;
                S0_AXIS_TREADY = M_AXIS_TREADY & ok0_s;
                GRANT          = 2'b01;
                if (hs0_s && S0_AXIS_TLAST) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b0;
                end else begin
                    state_d = ST_BUSY0;
                end
            end
            ST_BUSY1: begin
                M_AXIS_TDATA   = S1_AXIS_TDATA;
                M_AXIS_TKEEP   = S1_AXIS_TKEEP;
                M_AXIS_TLAST   = S1_AXIS_TLAST;
                M_AXIS_TVALID  = elig1_s;
                M_AXIS_TUSER   = 1'b1;
                S1_AXIS_TREADY = M_AXIS_TREADY & ok1_s;
                GRANT          = 2'b10;
                if (hs1_s && S1_AXIS_TLAST) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b1;
                end else begin
                    state_d = ST_BUSY1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and budget snapshots.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            cycle_count_q <= CW'(1);
            cnt0_q        <= 16'h0000;
            cnt1_q        <= 16'h0000;
            r_budget0_q   <= 16'h0000;
            r_budget1_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cycle_count_q <= cycle_count_d;
            cnt0_q        <= cnt0_d;
            cnt1_q        <= cnt1_d;
            r_budget0_q   <= BUDGET0;
            r_budget1_q   <= BUDGET1;
        end
    end

endmodule

// File: tb/tb_axis_budget_arbiter.sv
// Directed bench for axis_budget_arbiter: vector table plus multi-cycle
// sequences for budget stalls, window wrap and mid-packet reset.
module tb_axis_budget_arbiter;

    localparam int DW  = 512;
    localparam int CPU = 250;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [DW-1:0]   s0_data = '0, s1_data = '0;
    logic [DW/8-1:0] s0_keep = '1, s1_keep = {8{8'h5A}};
    logic            s0_last = 1'b0, s0_valid = 1'b0, s0_ready;
    logic            s1_last = 1'b0, s1_valid = 1'b0, s1_ready;
    logic [DW-1:0]   m_data;
    logic [DW/8-1:0] m_keep;
    logic            m_last, m_valid, m_user;
    logic            m_ready = 1'b1;
    logic [15:0]     budget0 = 16'd0, budget1 = 16'd0;
    logic [1:0]      grant;

    int n_chk  = 0;
    int n_fail = 0;
    int win    = 1;

    always #5 clk = ~clk;

    axis_budget_arbiter #(.DW(DW), .CLOCKS_PER_USEC(CPU)) dut (
        .clk(clk), .resetn(resetn),
        .S0_AXIS_TDATA(s0_data), .S0_AXIS_TKEEP(s0_keep), .S0_AXIS_TLAST(s0_last),
        .S0_AXIS_TVALID(s0_valid), .S0_AXIS_TREADY(s0_ready),
        .S1_AXIS_TDATA(s1_data), .S1_AXIS_TKEEP(s1_keep), .S1_AXIS_TLAST(s1_last),
        .S1_AXIS_TVALID(s1_valid), .S1_AXIS_TREADY(s1_ready),
        .M_AXIS_TDATA(m_data), .M_AXIS_TKEEP(m_keep), .M_AXIS_TLAST(m_last),
        .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TUSER(m_user),
        .BUDGET0(budget0), .BUDGET1(budget1), .GRANT(grant)
    );

    typedef struct {
        bit          rst;
        logic [15:0] b0, b1;
        logic        s0v, s0l, s1v, s1l, mr;
        logic [1:0]  g;
        logic        mv, ml, tu, s0r, s1r;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; the local window model tracks the DUT's cycle_count.
    task automatic next_cycle();
        @(posedge clk);
        win = (win == CPU) ? 1 : win + 1;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] b0, input logic [15:0] b1);
        resetn  = 1'b0;
        budget0 = b0;
        budget1 = b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        win    = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int beat, b10_win, b11_win, b16_win, order_err, saw_g1, c;
        int hs_pre, hs_wrap, hs_new, wrapped;

        // Reset state, sampled while resetn is held low.
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_s0ready", s0_ready, 1'b0);
        chk("rst_s1ready", s1_ready, 1'b0);

        // Port 0 only, 4-beat packets, budget 100, one downstream stall.
        vq.push_back('{1, 16'd100, 16'd100, 0,0,0,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,0,0,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,0,0,0,1, 2'b01,1,0,0,1,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,0,0,0,0, 2'b01,1,0,0,0,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,0,0,0,1, 2'b01,1,0,0,1,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,0,0,0,1, 2'b01,1,0,0,1,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,1,0,0,1, 2'b01,1,1,0,1,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,0,0,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd100, 16'd100, 1,0,0,0,1, 2'b01,1,0,0,1,0});
        // Both ports valid, 3-beat packets: grants 0 then 1 then 0.
        vq.push_back('{1, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b01,1,0,0,1,0});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b01,1,0,0,1,0});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,1,1,0,1, 2'b01,1,1,0,1,0});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b10,1,0,1,0,1});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b10,1,0,1,0,1});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,1,1, 2'b10,1,1,1,0,1});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd1000, 16'd1000, 1,0,1,0,1, 2'b01,1,0,0,1,0});
        // Budget 0 on port 1: never granted.
        vq.push_back('{1, 16'd100, 16'd0, 0,0,1,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd100, 16'd0, 0,0,1,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd100, 16'd0, 0,0,1,0,1, 2'b00,0,0,0,0,0});
        vq.push_back('{0, 16'd100, 16'd0, 0,0,1,0,1, 2'b00,0,0,0,0,0});

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) begin
                do_reset(vq[i].b0, vq[i].b1);
            end else begin
                budget0 = vq[i].b0;
                budget1 = vq[i].b1;
            end
            w = 32'hA000_0000 + 32'(i);
            s0_data  = {16{w}};
            w = 32'hB000_0000 + 32'(i);
            s1_data  = {16{w}};
            s0_valid = vq[i].s0v; s0_last = vq[i].s0l;
            s1_valid = vq[i].s1v; s1_last = vq[i].s1l;
            m_ready  = vq[i].mr;
            #2;
            chk($sformatf("v%0d_grant", i), grant, vq[i].g);
            chk($sformatf("v%0d_mvalid", i), m_valid, vq[i].mv);
            chk($sformatf("v%0d_mlast", i), m_last, vq[i].ml);
            chk($sformatf("v%0d_tuser", i), m_user, vq[i].tu);
            chk($sformatf("v%0d_s0ready", i), s0_ready, vq[i].s0r);
            chk($sformatf("v%0d_s1ready", i), s1_ready, vq[i].s1r);
            chk($sformatf("v%0d_tdata", i), m_data, (vq[i].g == 2'b10) ? s1_data : s0_data);
            chk($sformatf("v%0d_tkeep", i), m_keep, (vq[i].g == 2'b10) ? s1_keep : s0_keep);
            next_cycle();
        end

        // Budget 10, one 16-beat packet from port 0 while port 1 waits.
        s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
        do_reset(16'd10, 16'd1000);
        s0_valid = 1'b1; s1_valid = 1'b1; s1_last = 1'b0;
        beat = 0; b10_win = 0; b11_win = 0; b16_win = 0; order_err = 0; saw_g1 = 0; c = 0;
        while (c < 600 && beat < 16) begin
            s0_last = (beat == 15);
            w = 32'hC000_0000 + 32'(beat);
            s0_data = {16{w}};
            #2;
            if (grant == 2'b10) saw_g1 = 1;
            if (m_valid && m_ready) begin
                if (m_data[31:0] != w) order_err++;
                if (beat == 9)  b10_win = win;
                if (beat == 10) b11_win = win;
                if (beat == 15) b16_win = win;
                beat++;
            end
            if (win == 100) begin
                chk("c_stall_mvalid", m_valid, 1'b0);
                chk("c_stall_s0ready", s0_ready, 1'b0);
                chk("c_stall_grant", grant, 2'b01);
            end
            next_cycle();
            c++;
        end
        chk("c_beats", beat, 16);
        chk("c_beat10_win", b10_win, 12);
        chk("c_beat11_win", b11_win, 1);
        chk("c_beat16_win", b16_win, 6);
        chk("c_order", order_err, 0);
        chk("c_no_interleave", saw_g1, 0);
        s0_valid = 1'b0; s0_last = 1'b0;
        #2;
        chk("c_idle_after", grant, 2'b00);
        next_cycle();
        #2;
        chk("c_port1_next", grant, 2'b10);
        chk("c_port1_tuser", m_user, 1'b1);

        // Handshakes straddling the window wrap with budget 5.
        s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0;
        do_reset(16'd5, 16'd1000);
        c = 0;
        while (win != 248 && c < 400) begin
            next_cycle();
            c++;
        end
        s0_valid = 1'b1;
        hs_pre = 0; hs_wrap = 0; hs_new = 0; wrapped = 0; c = 0;
        while (!(wrapped && win == 8) && c < 40) begin
            #2;
            if (win == 1) wrapped = 1;
            if (m_valid && m_ready) begin
                if (win == 250) hs_wrap = 1;
                if (wrapped) hs_new++;
                else hs_pre++;
            end
            if (wrapped && win == 6) chk("e_stall_win6", m_valid, 1'b0);
            next_cycle();
            c++;
        end
        chk("e_hs_before_wrap", hs_pre, 2);
        chk("e_hs_on_wrap", hs_wrap, 1);
        chk("e_hs_new_window", hs_new, 5);

        // Asynchronous reset in the middle of a port-1 packet.
        s0_valid = 1'b0; s1_valid = 1'b0;
        do_reset(16'd100, 16'd100);
        s1_valid = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        chk("f_busy1", grant, 2'b10);
        chk("f_busy1_s1ready", s1_ready, 1'b1);
        resetn = 1'b0;
        #1;
        chk("f_rst_grant", grant, 2'b00);
        chk("f_rst_mvalid", m_valid, 1'b0);
        chk("f_rst_s1ready", s1_ready, 1'b0);
        s0_valid = 1'b1;
        do_reset(16'd100, 16'd100);
        #2;
        chk("f_after_idle", grant, 2'b00);
        next_cycle();
        next_cycle();
        #2;
        chk("f_port0_first", grant, 2'b01);
        chk("f_port0_tuser", m_user, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_budget_arbiter.md
Name: axis_budget_arbiter

Overview:
- Two-input, one-output AXI-Stream arbiter that shares a single egress datapath between two packet sources.
- Each source has its own per-microsecond transfer budget.
- Arbitration is packet-granular round-robin: once a port is granted, the grant holds until that port's TLAST handshake.
- Sits ahead of the egress link, giving per-source rate limiting and fair interleaving in one block.

Parameters:
DW, 512, data width in bits; TKEEP width is DW/8
CLOCKS_PER_USEC, 250, clk cycles per one-microsecond budget window

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
S0_AXIS_TDATA  input  DW  port 0 data
S0_AXIS_TKEEP  input  DW/8  port 0 byte enables
S0_AXIS_TLAST  input  1  port 0 end of packet
S0_AXIS_TVALID  input  1  port 0 valid
S0_AXIS_TREADY  output  1  port 0 ready
S1_AXIS_TDATA/TKEEP/TLAST/TVALID/TREADY  same as port 0, for port 1
M_AXIS_TDATA  output  DW  muxed data
M_AXIS_TKEEP  output  DW/8  muxed byte enables
M_AXIS_TLAST  output  1  muxed end of packet
M_AXIS_TVALID  output  1  muxed valid
M_AXIS_TREADY  input  1  downstream ready
M_AXIS_TUSER  output  1  source port of the current beat (0 or 1)
BUDGET0  input  16  port 0 max beats per window
BUDGET1  input  16  port 1 max beats per window
GRANT  output  2  one-hot current grant; 00 = idle

Behaviour:
- Reset is asynchronous and active-low. While resetn=0:
  - state=IDLE; GRANT=00; last_grant=1, so port 0 wins first.
  - cycle_count=1; cnt0=cnt1=0; r_budget0=r_budget1=0.
  - All TREADY=0 and M_AXIS_TVALID=0.
  - Reset asserted mid-packet abandons the packet; no flush is performed.
- BUDGET0/1 are registered every clk into r_budget0/1. All comparisons use the registered copies (one-cycle latency for budget changes).
- Window counter:
  - cycle_count runs 1..CLOCKS_PER_USEC and wraps to 1.
  - On the wrap cycle (cycle_count==CLOCKS_PER_USEC), cnt0 and cnt1 are cleared to 0.
  - If a handshake occurs on the wrap cycle, the clear wins: that beat counts against the old window only.
- Eligibility: eligN = SN_AXIS_TVALID & (cntN < r_budgetN). Compare is 16-bit unsigned. A budget of 0 means the port is never eligible.
- Counting: cntN increments on each M-side handshake while GRANT selects port N. cnt saturates at 16'hFFFF.
- State machine: IDLE, BUSY0, BUSY1.
  - IDLE:
    - Only one eligible port: grant it.
    - Both eligible: grant the port != last_grant.
    - Neither eligible: stay in IDLE.
    - Transition is registered. In IDLE all TREADY=0 and M_AXIS_TVALID=0, so minimum arbitration bubble is 1 cycle per packet.
  - BUSYn, combinational datapath:
    - M_AXIS_TDATA/TKEEP/TLAST = SN_AXIS_*
    - M_AXIS_TVALID = SN_AXIS_TVALID & (cntN < r_budgetN)
    - SN_AXIS_TREADY = M_AXIS_TREADY & (cntN < r_budgetN)
    - The other port's TREADY = 0.
    - M_AXIS_TUSER = N; GRANT one-hot bit N.
  - BUSYn -> IDLE on a handshake with TLAST=1; last_grant <= N on that edge.
- Budget exhausted mid-packet: the port stays granted and stalls (TVALID/TREADY low) until the next window clears cnt. The other port is never interleaved mid-packet.
- In IDLE, M_AXIS_TDATA/TKEEP/TLAST are driven from port 0 (don't-care); M_AXIS_TUSER=0.
- M_AXIS_TREADY low: no handshake, no count change, state held. AXIS stability rules are passed through unchanged.
- Latency: zero cycles data-path once granted; 1 cycle from eligibility to grant.

Test Plan:
- Only port 0 active, 4-beat packets, BUDGET0=100, TREADY=1 -> each packet takes 1 idle cycle plus 4 beats; TUSER=0; cnt0 reaches 4 per packet.
- Both ports continuously valid with 3-beat packets, budgets 1000 -> grants alternate 0,1,0,1 starting with port 0; no interleaving within a packet.
- BUDGET0=10, port 0 sending one 16-beat packet -> beats 1-10 pass; TVALID low until the wrap cycle (cycle_count 250 -> 1); beats 11-16 pass in the next window; port 1 never granted in between.
- BUDGET1=0, port 1 valid, port 0 idle -> GRANT stays 00 indefinitely and S1_AXIS_TREADY=0.
- Handshake on the wrap cycle with BUDGET0=5 -> cnt0=0 the cycle after, and 5 further beats are allowed.
- resetn pulsed low mid-packet during BUSY1 -> outputs drop immediately (asynchronous); after release, state=IDLE and port 0 is preferred when both ports are valid.
